// File: rtl/idma_lite_2d_midend_pkg.sv
// Shared types for the 2D iDMA midend: FSM state encoding and default widths.
package idma_lite_2d_midend_pkg;

  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefTFLenWidth = 32;
  localparam int unsigned DefRepWidth   = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } midend_state_e;

endpackage

// File: rtl/idma_lite_2d_midend.sv
// 2D midend: splits one strided 2D job into a sequence of 1D backend requests
// and folds the backend's per-transfer responses into one response per job.
module idma_lite_2d_midend
  import idma_lite_2d_midend_pkg::*;
#(
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned TFLenWidth = DefTFLenWidth,
  parameter int unsigned RepWidth   = DefRepWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // 2D job request
  input  logic                  nd_req_valid_i,
  output logic                  nd_req_ready_o,
  input  logic [TFLenWidth-1:0] nd_length_i,
  input  logic [AddrWidth-1:0]  nd_src_addr_i,
  input  logic [AddrWidth-1:0]  nd_dst_addr_i,
  input  logic [AddrWidth-1:0]  nd_src_stride_i,
  input  logic [AddrWidth-1:0]  nd_dst_stride_i,
  input  logic [RepWidth-1:0]   nd_num_reps_i,
  // 2D job response
  output logic                  nd_rsp_valid_o,
  input  logic                  nd_rsp_ready_i,
  output logic                  nd_rsp_error_o,
  // 1D request to backend
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [TFLenWidth-1:0] req_length_o,
  output logic [AddrWidth-1:0]  req_src_addr_o,
  output logic [AddrWidth-1:0]  req_dst_addr_o,
  output logic                  req_last_o,
  // 1D response from backend
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_error_i,
  input  logic                  rsp_last_i,
  output logic                  busy_o
);

  localparam int unsigned OutWidth = RepWidth + 1;

  typedef struct packed {
    logic [TFLenWidth-1:0] length;
    logic [AddrWidth-1:0]  src_addr;
    logic [AddrWidth-1:0]  dst_addr;
    logic [AddrWidth-1:0]  src_stride;
    logic [AddrWidth-1:0]  dst_stride;
    logic [RepWidth-1:0]   reps_left;
  } job_t;

  midend_state_e        state_q, state_d;
  job_t                 job_q, job_d;
  logic [OutWidth-1:0]  outstanding_q, outstanding_d;
  logic                 err_acc_q, err_acc_d;
  logic                 nd_rsp_valid_q, nd_rsp_valid_d;
  logic                 nd_rsp_error_q, nd_rsp_error_d;

  logic                 last_rep;
  logic                 req_hs;
  logic                 rsp_hs;

  assign last_rep = (job_q.reps_left == RepWidth'(1));
  assign req_hs   = req_valid_o & req_ready_i;
  assign rsp_hs   = rsp_valid_i & rsp_ready_o;

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d        = state_q;
    job_d          = job_q;
    nd_req_ready_o = 1'b0;
    req_valid_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        nd_req_ready_o = 1'b1;
        if (nd_req_valid_i) begin
          job_d.length     = nd_length_i;
          job_d.src_addr   = nd_src_addr_i;
          job_d.dst_addr   = nd_dst_addr_i;
          job_d.src_stride = nd_src_stride_i;
          job_d.dst_stride = nd_dst_stride_i;
          job_d.reps_left  = (nd_num_reps_i == '0) ? RepWidth'(1) : nd_num_reps_i;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        req_valid_o = 1'b1;
        // Payload only moves on a handshake, so a stalled request stays stable.
        if (req_ready_i) begin
          job_d.src_addr  = job_q.src_addr + job_q.src_stride;
          job_d.dst_addr  = job_q.dst_addr + job_q.dst_stride;
          job_d.reps_left = job_q.reps_left - RepWidth'(1);
          if (last_rep) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_length_o   = job_q.length;
  assign req_src_addr_o = job_q.src_addr;
  assign req_dst_addr_o = job_q.dst_addr;
  assign req_last_o     = (state_q == ISSUE) & last_rep;

  // ---------------------------------------------------------------------------
  // Response aggregation
  // ---------------------------------------------------------------------------
  assign rsp_ready_o = ~nd_rsp_valid_q | nd_rsp_ready_i;

  always_comb begin
    outstanding_d  = outstanding_q;
    err_acc_d      = err_acc_q;
    nd_rsp_valid_d = nd_rsp_valid_q;
    nd_rsp_error_d = nd_rsp_error_q;

    unique case ({req_hs, rsp_hs})
      2'b10:   outstanding_d = outstanding_q + OutWidth'(1);
      2'b01:   outstanding_d = outstanding_q - OutWidth'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (nd_rsp_valid_q && nd_rsp_ready_i) nd_rsp_valid_d = 1'b0;

    // A last response may land in the same cycle the old one drains; reload wins.
    if (rsp_hs) begin
      if (rsp_last_i) begin
        nd_rsp_valid_d = 1'b1;
        nd_rsp_error_d = err_acc_q | rsp_error_i;
        err_acc_d      = 1'b0;
      end else begin
        err_acc_d      = err_acc_q | rsp_error_i;
      end
    end
  end

  assign nd_rsp_valid_o = nd_rsp_valid_q;
  assign nd_rsp_error_o = nd_rsp_error_q;
  assign busy_o         = (state_q == ISSUE) | (outstanding_q != '0);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      job_q          <= '0;
      outstanding_q  <= '0;
      err_acc_q      <= 1'b0;
      nd_rsp_valid_q <= 1'b0;
      nd_rsp_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      job_q          <= job_d;
      outstanding_q  <= outstanding_d;
      err_acc_q      <= err_acc_d;
      nd_rsp_valid_q <= nd_rsp_valid_d;
      nd_rsp_error_q <= nd_rsp_error_d;
    end
  end

endmodule

// File: tb/tb_idma_lite_2d_midend.sv
// Self-checking bench for idma_lite_2d_midend: directed table, hand-written
// timing/back-pressure sequences and randomized jobs against a job-level model.
module tb_idma_lite_2d_midend;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        nd_req_valid_i, nd_req_ready_o;
  logic [31:0] nd_length_i, nd_src_addr_i, nd_dst_addr_i, nd_src_stride_i, nd_dst_stride_i;
  logic [15:0] nd_num_reps_i;
  logic        nd_rsp_valid_o, nd_rsp_ready_i, nd_rsp_error_o;
  logic        req_valid_o, req_ready_i, req_last_o;
  logic [31:0] req_length_o, req_src_addr_o, req_dst_addr_o;
  logic        rsp_valid_i, rsp_ready_o, rsp_error_i, rsp_last_i;
  logic        busy_o;

  always #5 clk = ~clk;

  idma_lite_2d_midend dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .nd_req_valid_i(nd_req_valid_i), .nd_req_ready_o(nd_req_ready_o),
    .nd_length_i(nd_length_i), .nd_src_addr_i(nd_src_addr_i), .nd_dst_addr_i(nd_dst_addr_i),
    .nd_src_stride_i(nd_src_stride_i), .nd_dst_stride_i(nd_dst_stride_i),
    .nd_num_reps_i(nd_num_reps_i),
    .nd_rsp_valid_o(nd_rsp_valid_o), .nd_rsp_ready_i(nd_rsp_ready_i), .nd_rsp_error_o(nd_rsp_error_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_length_o(req_length_o),
    .req_src_addr_o(req_src_addr_o), .req_dst_addr_o(req_dst_addr_o), .req_last_o(req_last_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o), .rsp_error_i(rsp_error_i),
    .rsp_last_i(rsp_last_i), .busy_o(busy_o)
  );

  typedef struct {
    logic [31:0] len, src, dst, ss, ds;
    logic [15:0] reps;
    logic [31:0] err_mask;
    bit          stall;
    int          exp_cnt;
    logic [31:0] exp_last_src, exp_last_dst;
    bit          exp_err;
  } vec_t;

  typedef struct { logic [31:0] len, src, dst; bit last; bit err; } req_t;
  typedef struct { bit err; bit last; } brsp_t;

  req_t        exp_req_q[$];
  brsp_t       bk_rsp_q[$];
  bit          exp_nd_q[$];
  int          total = 0;
  int          bad = 0;
  int          obs_req_cnt = 0;
  int          nd_cnt = 0;
  logic [31:0] obs_last_src, obs_last_dst;
  bit          obs_nd_err;
  int          ready_mode = 0;  // 0 random, 1 always ready, 2 scripted stall
  bit          nd_hold = 0;
  bit          run_bg = 0;
  int          stall_left = 0;
  bit          stall_armed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backend model: accepts 1D requests, compares them with the expected stream
  // and answers each one in order with the error flag chosen for it.
  initial begin : backend
    bit   presenting;
    bit   have_prev;
    req_t prev, e;
    presenting = 0;
    have_prev  = 0;
    req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_error_i = 1'b0; rsp_last_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!run_bg) continue;
      case (ready_mode)
        0:       req_ready_i = ($urandom_range(0, 3) != 0);
        1:       req_ready_i = 1'b1;
        default: req_ready_i = (stall_left == 0);
      endcase
      if (!presenting && bk_rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        presenting  = 1;
        rsp_valid_i = 1'b1;
        rsp_error_i = bk_rsp_q[0].err;
        rsp_last_i  = bk_rsp_q[0].last;
      end else if (!presenting) begin
        rsp_valid_i = 1'b0; rsp_error_i = 1'b0; rsp_last_i = 1'b0;
      end
      #1;
      if (have_prev) begin
        check("stall_valid", req_valid_o, 1'b1);
        check("stall_src", req_src_addr_o, prev.src);
        check("stall_dst", req_dst_addr_o, prev.dst);
        check("stall_len", req_length_o, prev.len);
        have_prev = 0;
      end
      if (req_valid_o) begin
        if (req_ready_i) begin
          if (exp_req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got src 0x%0h with no request expected", req_src_addr_o);
          end else begin
            e = exp_req_q.pop_front();
            check("req_len", req_length_o, e.len);
            check("req_src", req_src_addr_o, e.src);
            check("req_dst", req_dst_addr_o, e.dst);
            check("req_last", req_last_o, e.last);
            bk_rsp_q.push_back('{err: e.err, last: e.last});
          end
          obs_req_cnt++;
          if (req_last_o) begin
            obs_last_src = req_src_addr_o;
            obs_last_dst = req_dst_addr_o;
          end
          if (ready_mode == 2 && stall_armed) begin
            stall_left  = 5;
            stall_armed = 0;
          end
        end else begin
          have_prev = 1;
          prev = '{len: req_length_o, src: req_src_addr_o, dst: req_dst_addr_o, last: req_last_o, err: 0};
          if (stall_left > 0) stall_left--;
        end
      end
      if (presenting && rsp_ready_o) begin
        void'(bk_rsp_q.pop_front());
        presenting = 0;
      end
    end
  end

  // Upstream consumer of 2D job responses.
  initial begin : nd_consumer
    nd_rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!run_bg) continue;
      nd_rsp_ready_i = nd_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      #1;
      if (nd_rsp_valid_o && nd_rsp_ready_i) begin
        if (exp_nd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_nd_rsp: got response with no job outstanding");
        end else begin
          check("nd_rsp_error", nd_rsp_error_o, exp_nd_q.pop_front());
        end
        obs_nd_err = nd_rsp_error_o;
        nd_cnt++;
      end
    end
  end

  // Job-level model: rep k goes to base + k*stride (mod 2^32); the job's
  // response error is the OR of the errors chosen for its repetitions.
  task automatic send_job(input vec_t j);
    int          n;
    bit          agg, acc;
    logic [31:0] kk;
    req_t        r;
    n   = (j.reps == 0) ? 1 : int'(j.reps);
    agg = 0;
    acc = 0;
    @(negedge clk);
    nd_length_i = j.len; nd_src_addr_i = j.src; nd_dst_addr_i = j.dst;
    nd_src_stride_i = j.ss; nd_dst_stride_i = j.ds; nd_num_reps_i = j.reps;
    nd_req_valid_i = 1'b1;
    for (int c = 0; c < 500 && !acc; c++) begin
      #1;
      if (nd_req_ready_o) acc = 1;
      else @(negedge clk);
    end
    check("job_accepted", acc, 1'b1);
    if (acc) begin
      for (int k = 0; k < n; k++) begin
        kk    = k;
        r.len = j.len;
        r.src = j.src + kk * j.ss;
        r.dst = j.dst + kk * j.ds;
        r.last = (k == n - 1);
        r.err  = j.err_mask[k];
        agg   |= r.err;
        exp_req_q.push_back(r);
      end
      exp_nd_q.push_back(agg);
    end
    @(negedge clk);
    nd_req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      #2;
      if (exp_req_q.size() == 0 && bk_rsp_q.size() == 0 && exp_nd_q.size() == 0 &&
          !busy_o && !nd_rsp_valid_o) done = 1;
    end
    check("idle_reached", done, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[6];
    vec_t j;
    int   base, cnt0;
    bit   seen;

    rst_ni = 1'b0;
    nd_req_valid_i = 1'b0; nd_length_i = '0; nd_src_addr_i = '0; nd_dst_addr_i = '0;
    nd_src_stride_i = '0; nd_dst_stride_i = '0; nd_num_reps_i = '0;

    vecs[0] = '{32'd64, 32'h1000, 32'h2000, 32'h100, 32'h200, 16'd3, 32'h0, 0, 3, 32'h1200, 32'h2400, 0};
    vecs[1] = '{32'd16, 32'h40, 32'h80, 32'h4, 32'h8, 16'd0, 32'h0, 0, 1, 32'h40, 32'h80, 0};
    vecs[2] = '{32'd8, 32'hFFFF_FF00, 32'h3000, 32'h100, 32'h10, 16'd2, 32'h0, 0, 2, 32'h0, 32'h3010, 0};
    vecs[3] = '{32'd8, 32'h100, 32'h200, 32'h20, 32'hFFFF_FFF0, 16'd3, 32'h1, 0, 3, 32'h140, 32'h1E0, 1};
    vecs[4] = '{32'd4, 32'h0, 32'h0, 32'h1, 32'h1, 16'd1, 32'h0, 0, 1, 32'h0, 32'h0, 0};
    vecs[5] = '{32'd32, 32'h5000, 32'h6000, 32'h40, 32'h80, 16'd3, 32'h0, 1, 3, 32'h5080, 32'h6100, 0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_nd_req_ready", nd_req_ready_o, 1'b1);
    check("rst_req_valid", req_valid_o, 1'b0);
    check("rst_req_last", req_last_o, 1'b0);
    check("rst_req_len", req_length_o, 32'h0);
    check("rst_req_src", req_src_addr_o, 32'h0);
    check("rst_req_dst", req_dst_addr_o, 32'h0);
    check("rst_nd_rsp_valid", nd_rsp_valid_o, 1'b0);
    check("rst_nd_rsp_error", nd_rsp_error_o, 1'b0);
    check("rst_rsp_ready", rsp_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    run_bg = 1;

    // Issue timing: request in t+1, back-to-back reps, one IDLE bubble.
    ready_mode = 1;
    send_job(vecs[0]);
    #1;
    check("t1_req_valid", req_valid_o, 1'b1);
    check("t1_nd_ready_low", nd_req_ready_o, 1'b0);
    check("t1_not_last", req_last_o, 1'b0);
    @(negedge clk); #1;
    check("t2_req_valid", req_valid_o, 1'b1);
    @(negedge clk); #1;
    check("t3_req_valid", req_valid_o, 1'b1);
    check("t3_last", req_last_o, 1'b1);
    @(negedge clk); #1;
    check("t4_req_idle", req_valid_o, 1'b0);
    check("t4_nd_ready", nd_req_ready_o, 1'b1);
    wait_idle();

    // Directed table.
    foreach (vecs[i]) begin
      ready_mode  = vecs[i].stall ? 2 : 0;
      stall_armed = vecs[i].stall;
      base = obs_req_cnt;
      send_job(vecs[i]);
      wait_idle();
      check($sformatf("v%0d_count", i), obs_req_cnt - base, vecs[i].exp_cnt);
      check($sformatf("v%0d_last_src", i), obs_last_src, vecs[i].exp_last_src);
      check($sformatf("v%0d_last_dst", i), obs_last_dst, vecs[i].exp_last_dst);
      check($sformatf("v%0d_nd_err", i), obs_nd_err, vecs[i].exp_err);
    end

    // Response back-pressure: two jobs finish while upstream is not ready.
    ready_mode = 1;
    nd_hold = 1;
    cnt0 = nd_cnt;
    send_job(vecs[4]);
    send_job(vecs[1]);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk); #2;
      if (rsp_valid_i && !rsp_ready_o) seen = 1;
    end
    check("bp_rsp_ready_low", seen, 1'b1);
    check("bp_nd_valid_held", nd_rsp_valid_o, 1'b1);
    check("bp_busy", busy_o, 1'b1);
    nd_hold = 0;
    wait_idle();
    check("bp_two_delivered", nd_cnt - cnt0, 2);
    check("bp_busy_end", busy_o, 1'b0);

    // Randomized back-to-back jobs against the model.
    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      j.len  = $urandom;
      j.src  = $urandom;
      j.dst  = $urandom;
      j.ss   = $urandom;
      j.ds   = $urandom;
      j.reps = 16'($urandom_range(0, 6));
      j.err_mask = '0;
      for (int b = 0; b < 8; b++) j.err_mask[b] = ($urandom_range(0, 7) == 0);
      j.stall = 0;
      send_job(j);
    end
    wait_idle();
    check("rand_busy_end", busy_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
